test_stream_source: RTL and testbench
=====================================

# test_stream_source

AXI4-Stream test pattern generator. Idles with `idle` high until `start` is pulsed, then emits one packet of `packet_length` beats of incrementing 32-bit data, asserting `tlast` on the final beat. Optional inter-beat gaps throttle the offered bandwidth. Sits directly upstream of `test_stream_sink` in the loopback/bandwidth test path; it also counts accepted beats and backpressure stalls so source-side and sink-side counts can be compared.

## Interface
Parameters:
- `GAP_WIDTH`, default 8: width of the `gap_cycles` input.

Ports:
- `clk`  in  1  clock; the only clock in the block.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse; acted on only when `idle`=1.
- `idle`  out  1  high when no packet is in progress.
- `packet_length`  in  32  number of beats in the packet; latched on an accepted start.
- `first_value`  in  32  `tdata` of beat 0; latched on an accepted start.
- `gap_cycles`  in  GAP_WIDTH  number of cycles with `tvalid` low inserted after each non-final handshake; latched on an accepted start.
- `m_tvalid`  out  1  AXI4-Stream valid.
- `m_tready`  in  1  AXI4-Stream ready.
- `m_tdata`  out  32  AXI4-Stream data.
- `m_tlast`  out  1  high on the final beat.
- `beat_count`  out  32  handshakes (tvalid&tready) since the last accepted start.
- `stall_count`  out  32  cycles with tvalid&~tready since the last accepted start.

## Operation
- States: IDLE, SEND, GAP. All outputs are registered.
- IDLE: `m_tvalid`=0, `idle`=1.
  - If `start`=1 and `packet_length`≠0, the block:
    - latches length, `first_value`, and `gap_cycles`;
    - loads `data` with `first_value` and `remaining` with `packet_length`;
    - clears both counters;
    - moves to SEND.
  - `start` with `packet_length`=0 is ignored: the state stays IDLE and the counters are untouched.
- SEND: `m_tvalid`=1, `m_tdata`=`data`, `m_tlast`=(`remaining`==1).
  - On a handshake:
    - `beat_count`+1;
    - `data`+1, wrapping mod 2^32 (0xFFFFFFFF → 0);
    - `remaining`−1.
    - If the beat was last, go to IDLE. Else if the gap is 0, stay in SEND (back-to-back beats). Else load `gapcnt`=gap and go to GAP.
  - Without a handshake: `stall_count`+1. `m_tdata` and `m_tlast` hold stable; `m_tvalid` never drops before the handshake.
- GAP: `m_tvalid`=0 and no counting. `gapcnt` decrements each cycle; when `gapcnt`==1, go to SEND. This gives exactly `gap_cycles` low-valid cycles.
- `start` while not IDLE is ignored. Inputs are sampled only on an accepted start, so changes mid-packet have no effect.
- Counters wrap at 2^32 with no saturation. They hold their values in IDLE so they can be read after the packet.
- `first_value`=0 matches the downstream sink's expected-data reset value, so back-to-back packets check clean.
- Reset values: `idle`=1, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `beat_count`=0, `stall_count`=0, state IDLE.
- Reset asserted mid-packet takes effect at the next edge: the packet is abandoned, all outputs go to their reset values, and there is no `tlast`.

## Timing
- Accepted `start` at edge N: at N+1, `idle`=0, `m_tvalid`=1, `m_tdata`=`first_value`, and both counters read 0.
- Gap 0 with `m_tready` held high: one beat per cycle, so a packet of L beats occupies L cycles of `m_tvalid`.
- Gap G with ready held high: each beat is followed by G cycles of valid low, so a packet takes L+(L−1)·G cycles.
- Last handshake at edge M: at M+1, `idle`=1, `m_tvalid`=0, `m_tlast`=0, and `beat_count`=L.
- Earliest restart: `start` at M+1 is accepted, and the next packet's `tvalid` rises at M+2.
- `packet_length`=1: the first beat carries `m_tlast`=1.

## Test plan
- L=4, first=0x10, gap 0, ready=1 → tdata 0x10..0x13 on 4 consecutive cycles; tlast only on 0x13; `idle` high the next cycle; `beat_count`=4, `stall_count`=0.
- L=3, gap=2, ready=1 → valid pattern 1,0,0,1,0,0,1; `beat_count`=3.
- L=2, ready low for 5 cycles then high → beat 0 holds stable for 5 cycles; `stall_count`=5, `beat_count`=2.
- first=0xFFFFFFFE, L=3 → tdata FFFFFFFE, FFFFFFFF, 00000000.
- `start` with L=0 → stays idle, counters unchanged. `start` pulsed mid-packet → ignored, packet length unchanged.
- `resetn` low for 1 cycle during beat 2 of L=8 → `m_tvalid`=0, `idle`=1, counters 0 next cycle; a new start then sends a full packet from `first_value`.

Source files
------------

// File: rtl/test_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : test_stream_source
// Description : AXI4-Stream test pattern generator. On an accepted start it
//               emits one packet of incrementing 32-bit words with tlast on
//               the final beat, optionally inserting idle gaps after each
//               non-final beat, and counts handshakes and stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module test_stream_source #(
    parameter int GAP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 idle,
    input  logic [31:0]          packet_length,
    input  logic [31:0]          first_value,
    input  logic [GAP_WIDTH-1:0] gap_cycles,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [31:0]          m_tdata,
    output logic                 m_tlast,
    output logic [31:0]          beat_count,
    output logic [31:0]          stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          remaining_q, remaining_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [GAP_WIDTH-1:0] gapcnt_q, gapcnt_d;
    logic [31:0]          beat_count_q, beat_count_d;
    logic [31:0]          stall_count_q, stall_count_d;
    logic                 idle_q, idle_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;

    // Next-state and next-output computation; every output is a flop, so
    // valid/last for the coming cycle are decided here alongside the state.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        remaining_d   = remaining_q;
        gap_d         = gap_q;
        gapcnt_d      = gapcnt_q;
        beat_count_d  = beat_count_q;
        stall_count_d = stall_count_q;
        idle_d        = idle_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;

        case (state_q)
            ST_IDLE: begin
                // A zero-length request is dropped without touching counters.
                if (start && (packet_length != 32'd0)) begin
                    state_d       = ST_SEND;
                    data_d        = first_value;
                    remaining_d   = packet_length;
                    gap_d         = gap_cycles;
                    beat_count_d  = 32'd0;
                    stall_count_d = 32'd0;
                    idle_d        = 1'b0;
                    tvalid_d      = 1'b1;
                    tlast_d       = (packet_length == 32'd1);
                end
            end

            ST_SEND: begin
                if (m_tready) begin
                    beat_count_d = beat_count_q + 32'd1;
                    data_d       = data_q + 32'd1;
                    remaining_d  = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d  = ST_IDLE;
                        idle_d   = 1'b1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else if (gap_q == '0) begin
                        // Back-to-back: next beat is last if two remained.
                        tlast_d = (remaining_q == 32'd2);
                    end else begin
                        state_d  = ST_GAP;
                        gapcnt_d = gap_q;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end else begin
                    stall_count_d = stall_count_q + 32'd1;
                end
            end

            ST_GAP: begin
                gapcnt_d = gapcnt_q - 1'b1;
                if (gapcnt_q == {{(GAP_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = (remaining_q == 32'd1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                idle_d   = 1'b1;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            data_q        <= 32'd0;
            remaining_q   <= 32'd0;
            gap_q         <= '0;
            gapcnt_q      <= '0;
            beat_count_q  <= 32'd0;
            stall_count_q <= 32'd0;
            idle_q        <= 1'b1;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            remaining_q   <= remaining_d;
            gap_q         <= gap_d;
            gapcnt_q      <= gapcnt_d;
            beat_count_q  <= beat_count_d;
            stall_count_q <= stall_count_d;
            idle_q        <= idle_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
        end
    end

    assign idle        = idle_q;
    assign m_tvalid    = tvalid_q;
    assign m_tdata     = data_q;
    assign m_tlast     = tlast_q;
    assign beat_count  = beat_count_q;
    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_test_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_stream_source
// Description : Self-checking bench for test_stream_source. Each packet is
//               checked against the expected beat sequence, gap lengths,
//               stall/beat counts and overall packet duration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_stream_source;

    localparam int GAP_WIDTH = 8;

    logic                 clk;
    logic                 resetn;
    logic                 start;
    logic                 idle;
    logic [31:0]          packet_length;
    logic [31:0]          first_value;
    logic [GAP_WIDTH-1:0] gap_cycles;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [31:0]          m_tdata;
    logic                 m_tlast;
    logic [31:0]          beat_count;
    logic [31:0]          stall_count;

    int checks;
    int failures;
    int last_beats;
    int last_stalls;

    test_stream_source #(.GAP_WIDTH(GAP_WIDTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .idle         (idle),
        .packet_length(packet_length),
        .first_value  (first_value),
        .gap_cycles   (gap_cycles),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .beat_count   (beat_count),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one packet starting at a negedge while idle; ends at the negedge
    // right after the final handshake. Ready is held low for the first
    // hold_low valid cycles, then high with probability pct percent.
    task automatic run_packet(input int len, input logic [31:0] first, input int gap,
                              input int pct, input int hold_low, input bit mid_start);
        int idx = 0;
        int stalls = 0;
        int low_run = 0;
        int vcyc = 0;
        int cyc = 0;
        int budget;
        bit in_gap = 0;
        bit done = 0;
        bit mid_done = 0;
        logic [31:0] exp_data;
        budget = len * (gap + 1) + hold_low + 400;

        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL pre_start_idle got=%b exp=1", idle);
        end
        start = 1'b1;
        packet_length = len;
        first_value = first;
        gap_cycles = GAP_WIDTH'(gap);
        @(negedge clk);
        start = 1'b0;

        checks++;
        if (idle !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== first ||
            beat_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL start_response got idle=%b valid=%b data=%h beats=%0d stalls=%0d exp idle=0 valid=1 data=%h beats=0 stalls=0",
                     idle, m_tvalid, m_tdata, beat_count, stall_count, first);
        end

        while (!done && cyc < budget) begin
            // Inputs other than start must be ignored once the packet runs.
            packet_length = $urandom;
            first_value   = $urandom;
            gap_cycles    = GAP_WIDTH'($urandom);
            if (m_tvalid === 1'b1) begin
                exp_data = first + 32'(idx);
                checks++;
                if (m_tdata !== exp_data) begin
                    failures++;
                    $display("FAIL tdata beat=%0d got=%h exp=%h", idx, m_tdata, exp_data);
                end
                checks++;
                if (m_tlast !== (idx == len - 1)) begin
                    failures++;
                    $display("FAIL tlast beat=%0d got=%b exp=%b", idx, m_tlast, (idx == len - 1));
                end
                if (in_gap) begin
                    checks++;
                    if (low_run != gap) begin
                        failures++;
                        $display("FAIL gap_len beat=%0d got=%0d exp=%0d", idx, low_run, gap);
                    end
                    in_gap = 0;
                end
                vcyc++;
                m_tready = (vcyc > hold_low) && ($urandom_range(0, 99) < pct);
                if (m_tready) begin
                    idx++;
                    if (idx == len) done = 1;
                    else begin
                        in_gap = 1;
                        low_run = 0;
                    end
                end else begin
                    stalls++;
                end
            end else begin
                checks++;
                if (!in_gap) begin
                    failures++;
                    $display("FAIL valid_drop beat=%0d got=0 exp=1", idx);
                end
                low_run++;
                m_tready = 1'($urandom_range(0, 1));
            end
            if (mid_start && !mid_done && idx == 2 && !done) begin
                start = 1'b1;
                mid_done = 1;
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end

        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout beats_seen=%0d exp=%0d", idx, len);
        end else begin
            checks++;
            if (cyc != len + (len - 1) * gap + stalls) begin
                failures++;
                $display("FAIL packet_cycles got=%0d exp=%0d", cyc, len + (len - 1) * gap + stalls);
            end
        end

        checks++;
        if (idle !== 1'b1 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
            beat_count !== 32'(len) || stall_count !== 32'(stalls)) begin
            failures++;
            $display("FAIL end_state got idle=%b valid=%b last=%b beats=%0d stalls=%0d exp idle=1 valid=0 last=0 beats=%0d stalls=%0d",
                     idle, m_tvalid, m_tlast, beat_count, stall_count, len, stalls);
        end
        m_tready = 1'b0;
        last_beats = len;
        last_stalls = stalls;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        m_tready = 1'b0;
        packet_length = 32'd0;
        first_value = 32'd0;
        gap_cycles = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (idle !== 1'b1 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'd0 ||
            beat_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got idle=%b valid=%b last=%b data=%h beats=%0d stalls=%0d exp 1 0 0 0 0 0",
                     idle, m_tvalid, m_tlast, m_tdata, beat_count, stall_count);
        end
        resetn = 1'b1;
        @(negedge clk);
        last_beats = 0;
        last_stalls = 0;
    endtask

    task automatic test_basic();
        run_packet(4, 32'h10, 0, 100, 0, 0);
        run_packet(1, 32'h55, 0, 100, 0, 0);
    endtask

    task automatic test_gap();
        run_packet(3, 32'h100, 2, 100, 0, 0);
    endtask

    task automatic test_stall();
        run_packet(2, 32'h200, 0, 100, 5, 0);
    endtask

    task automatic test_wrap();
        run_packet(3, 32'hFFFF_FFFE, 0, 100, 0, 0);
    endtask

    task automatic test_zero_len();
        start = 1'b1;
        packet_length = 32'd0;
        first_value = 32'h1234;
        gap_cycles = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (idle !== 1'b1 || m_tvalid !== 1'b0 ||
                beat_count !== 32'(last_beats) || stall_count !== 32'(last_stalls)) begin
                failures++;
                $display("FAIL zero_len got idle=%b valid=%b beats=%0d stalls=%0d exp idle=1 valid=0 beats=%0d stalls=%0d",
                         idle, m_tvalid, beat_count, stall_count, last_beats, last_stalls);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_start();
        run_packet(5, 32'h3000, 1, 100, 0, 1);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        packet_length = 32'd8;
        first_value = 32'hA5A5_0000;
        gap_cycles = '0;
        m_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5A5_0002) begin
            failures++;
            $display("FAIL reset_mid_beat2 got valid=%b data=%h exp valid=1 data=a5a50002", m_tvalid, m_tdata);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_tready = 1'b0;
        checks++;
        if (idle !== 1'b1 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'd0 ||
            beat_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got idle=%b valid=%b last=%b data=%h beats=%0d stalls=%0d exp 1 0 0 0 0 0",
                     idle, m_tvalid, m_tlast, m_tdata, beat_count, stall_count);
        end
        run_packet(8, 32'hA5A5_0000, 0, 100, 0, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            run_packet($urandom_range(1, 12), $urandom, $urandom_range(0, 3),
                       $urandom_range(40, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_packet(3, 32'h0, 0, 100, 0, 0);
        run_packet(2, 32'h0, 1, 100, 0, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_gap();
        test_stall();
        test_zero_len();
        test_wrap();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
